// File: rtl/simd_ctrl_seq.sv
// SIMD control sequencer: fetch/decode/issue FSM over a sync-read imem with a valid/ready issue port.
// Optional build macro SIMD_CTRL_TRAP_EN: an undefined opcode halts instead of retiring as a NOP.
module simd_ctrl_seq #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 32,
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic               imem_rd_en,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic               add_en,
   output logic               sub_en,
   output logic               mul_en,
   output logic               bitrev_en,
   output logic               rs1_rd_en,
   output logic               rs2_rd_en,
   output logic               rd_wr_en,
   output logic [REG_AW-1:0]  rs1,
   output logic [REG_AW-1:0]  rs2,
   output logic [REG_AW-1:0]  rd,
   output logic [1:0]         elem_mode,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               halted,
   output logic               illegal
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_MUL, S_HALTED
   } state_e;

   typedef enum logic [5:0] {
      OP_NOP = 6'h00, OP_ADD = 6'h01, OP_SUB = 6'h02,
      OP_MUL = 6'h03, OP_BITREV = 6'h04, OP_HALT = 6'h3F
   } op_e;

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);
   localparam bit HAS_MUL_WAIT = (MUL_LAT > 0);

   state_e             r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [31:0]        r_instr;
   logic [CNT_W-1:0]   r_mul_cnt;
   logic               r_rd_en, r_valid, r_add, r_sub, r_mul, r_bitrev;
   logic               r_rs1_en, r_rs2_en, r_wr_en, r_halted, r_illegal;
   logic [REG_AW-1:0]  r_rs1, r_rs2, r_rd;
   logic [1:0]         r_mode;

   logic [5:0]         w_op;
   logic               w_legal_alu;
   logic [1:0]         w_mode;
   logic [ADDR_W-1:0]  w_pc_inc;
   state_e             w_retire_state;
   logic               w_unused;

   assign w_op           = imem_rdata[31:26];
   // Reserved lane mode 11 is presented downstream as plain 32b lanes.
   assign w_mode         = (imem_rdata[10:9] == 2'b11) ? 2'b10 : imem_rdata[10:9];
   assign w_pc_inc       = r_pc + ADDR_W'(1);
   assign w_retire_state = enable ? S_FETCH : S_IDLE;
   assign w_unused       = ^{imem_rdata, r_instr};

   always_comb begin
      w_legal_alu = 1'b0;
      case (w_op)
         OP_ADD, OP_SUB, OP_MUL, OP_BITREV: w_legal_alu = 1'b1;
         default:                           w_legal_alu = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_instr   <= '0;
         r_mul_cnt <= '0;
         r_rd_en   <= 1'b0;
         r_valid   <= 1'b0;
         r_add     <= 1'b0;
         r_sub     <= 1'b0;
         r_mul     <= 1'b0;
         r_bitrev  <= 1'b0;
         r_rs1_en  <= 1'b0;
         r_rs2_en  <= 1'b0;
         r_wr_en   <= 1'b0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_mode    <= '0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_state <= S_FETCH;
                  r_rd_en <= 1'b1;
               end
            end
            S_FETCH: begin
               r_rd_en <= 1'b0;
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_instr <= imem_rdata[31:0];
               if (w_op == OP_HALT) begin
                  r_state  <= S_HALTED;
                  r_halted <= 1'b1;
               end else if (w_legal_alu) begin
                  r_state  <= S_ISSUE;
                  r_valid  <= 1'b1;
                  r_add    <= (w_op == OP_ADD);
                  r_sub    <= (w_op == OP_SUB);
                  r_mul    <= (w_op == OP_MUL);
                  r_bitrev <= (w_op == OP_BITREV);
                  r_rs1_en <= 1'b1;
                  r_rs2_en <= (w_op != OP_BITREV);
                  r_wr_en  <= 1'b1;
                  r_rd     <= REG_AW'(imem_rdata[25:21]);
                  r_rs1    <= REG_AW'(imem_rdata[20:16]);
                  r_rs2    <= REG_AW'(imem_rdata[15:11]);
                  r_mode   <= w_mode;
               end else begin
                  if (w_op != OP_NOP) begin
                     r_illegal <= 1'b1;
                  end
`ifdef SIMD_CTRL_TRAP_EN
                  if (w_op != OP_NOP) begin
                     r_state  <= S_HALTED;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc    <= w_pc_inc;
                     r_state <= w_retire_state;
                     r_rd_en <= enable;
                  end
`else
                  r_pc    <= w_pc_inc;
                  r_state <= w_retire_state;
                  r_rd_en <= enable;
`endif
               end
            end
            S_ISSUE: begin
               if (issue_ready) begin
                  r_valid  <= 1'b0;
                  r_add    <= 1'b0;
                  r_sub    <= 1'b0;
                  r_mul    <= 1'b0;
                  r_bitrev <= 1'b0;
                  r_rs1_en <= 1'b0;
                  r_rs2_en <= 1'b0;
                  r_wr_en  <= 1'b0;
                  r_rs1    <= '0;
                  r_rs2    <= '0;
                  r_rd     <= '0;
                  r_mode   <= '0;
                  if (HAS_MUL_WAIT && r_instr[31:26] == OP_MUL) begin
                     r_state   <= S_WAIT_MUL;
                     r_mul_cnt <= '0;
                  end else begin
                     r_pc    <= w_pc_inc;
                     r_state <= w_retire_state;
                     r_rd_en <= enable;
                  end
               end
            end
            S_WAIT_MUL: begin
               if (r_mul_cnt == MUL_LAST) begin
                  r_mul_cnt <= '0;
                  r_pc      <= w_pc_inc;
                  r_state   <= w_retire_state;
                  r_rd_en   <= enable;
               end else begin
                  r_mul_cnt <= r_mul_cnt + CNT_W'(1);
               end
            end
            S_HALTED: begin
               r_state <= S_HALTED;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_addr   = r_pc;
   assign imem_rd_en  = r_rd_en;
   assign issue_valid = r_valid;
   assign add_en      = r_add;
   assign sub_en      = r_sub;
   assign mul_en      = r_mul;
   assign bitrev_en   = r_bitrev;
   assign rs1_rd_en   = r_rs1_en;
   assign rs2_rd_en   = r_rs2_en;
   assign rd_wr_en    = r_wr_en;
   assign rs1         = r_rs1;
   assign rs2         = r_rs2;
   assign rd          = r_rd;
   assign elem_mode   = r_mode;
   assign pc          = r_pc;
   assign busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
   assign halted      = r_halted;
   assign illegal     = r_illegal;

endmodule
